// File: rtl/dm_pkg.sv
// Shared defaults and helpers for the dual-port data memory.
package dm_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 13;
  localparam int unsigned DefDepth = 8192;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned BeW      = DefDataW / 8;

  // Expand byte-lane enables into a bit mask over the data word.
  function automatic logic [DefDataW-1:0] be_mask(input logic [BeW-1:0] be);
    logic [DefDataW-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(BeW); i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_dp_if.sv
// Port A (CPU, never stalls) and port B (req/gnt) bus of the dual-port data memory.
interface data_mem_dp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              a_re;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [BE_W-1:0]   a_be;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  logic              a_err;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [BE_W-1:0]   b_be;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;

  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output a_re, a_we, a_addr, a_be, a_wdata,
    input  a_rdata, a_rvalid, a_err,
    output b_req, b_we, b_addr, b_be, b_wdata,
    input  b_gnt, b_rdata, b_rvalid,
    input  conflict_cnt
  );

  modport slave (
    input  a_re, a_we, a_addr, a_be, a_wdata,
    output a_rdata, a_rvalid, a_err,
    input  b_req, b_we, b_addr, b_be, b_wdata,
    output b_gnt, b_rdata, b_rvalid,
    output conflict_cnt
  );

endinterface

// File: rtl/dm_bank_dp.sv
// Raw true dual-port byte-writable array with registered read data (block RAM template).
module dm_bank_dp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 8192
) (
  input  logic                clk_i,
  input  logic                a_rd_en_i,
  input  logic                a_wr_en_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W/8-1:0] a_be_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                b_rd_en_i,
  input  logic                b_wr_en_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W/8-1:0] b_be_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic [DATA_W-1:0]   b_rdata_o
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Enables arrive pre-arbitrated: no same-address write/access pair ever reaches here.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (a_wr_en_i && a_be_i[i]) mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
      if (b_wr_en_i && b_be_i[i]) mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
    end
    if (a_rd_en_i) a_rdata_q <= mem_q[a_addr_i];
    if (b_rd_en_i) b_rdata_q <= mem_q[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/data_mem_dp.sv
// Dual-port data memory: port A always wins, port B is granted around same-address conflicts.
module data_mem_dp
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned CNT_W  = DefCntW
) (
  input logic         clk,
  input logic         rst_n,
  data_mem_dp_if.slave bus
);
  localparam logic [ADDR_W:0]  DepthLim = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic a_rd, a_wr, a_ill, a_oor, b_oor;
  logic conflict, b_gnt, b_go;
  logic [DATA_W-1:0] bank_a_rdata, bank_b_rdata;
  logic a_rvalid_q, b_rvalid_q, a_err_q;
  logic a_zero_q, b_zero_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign a_rd  = bus.a_re & ~bus.a_we;
  assign a_wr  = bus.a_we & ~bus.a_re;
  assign a_ill = bus.a_re & bus.a_we;
  assign a_oor = {1'b0, bus.a_addr} >= DepthLim;
  assign b_oor = {1'b0, bus.b_addr} >= DepthLim;

  assign conflict = (a_rd | a_wr) & bus.b_req & (bus.a_addr == bus.b_addr) & (a_wr | bus.b_we);
  assign b_gnt    = rst_n & bus.b_req & ~conflict;
  assign b_go     = bus.b_req & b_gnt;

  // Writes are gated by rst_n so an edge that sees reset low commits nothing.
  dm_bank_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk_i     (clk),
    .a_rd_en_i (a_rd & ~a_oor & rst_n),
    .a_wr_en_i (a_wr & ~a_oor & rst_n),
    .a_addr_i  (bus.a_addr),
    .a_be_i    (bus.a_be),
    .a_wdata_i (bus.a_wdata),
    .a_rdata_o (bank_a_rdata),
    .b_rd_en_i (b_go & ~bus.b_we & ~b_oor),
    .b_wr_en_i (b_go & bus.b_we & ~b_oor),
    .b_addr_i  (bus.b_addr),
    .b_be_i    (bus.b_be),
    .b_wdata_i (bus.b_wdata),
    .b_rdata_o (bank_b_rdata)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (bus.b_req && !b_gnt && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
  end

  // zero flags mask the unreset bank registers after reset or an out-of-range read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      a_zero_q   <= 1'b1;
      b_zero_q   <= 1'b1;
      cnt_q      <= '0;
    end else begin
      a_rvalid_q <= a_rd;
      a_err_q    <= a_ill | ((a_rd | a_wr) & a_oor);
      if (a_rd) a_zero_q <= a_oor;
      b_rvalid_q <= b_go & ~bus.b_we;
      if (b_go && !bus.b_we) b_zero_q <= b_oor;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.a_rdata      = a_zero_q ? '0 : bank_a_rdata;
  assign bus.b_rdata      = b_zero_q ? '0 : bank_b_rdata;
  assign bus.a_rvalid     = a_rvalid_q;
  assign bus.b_rvalid     = b_rvalid_q;
  assign bus.a_err        = a_err_q;
  assign bus.b_gnt        = b_gnt;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_data_mem_dp.sv
// Directed vector bench for data_mem_dp (DEPTH = 6000, 3-bit counter to reach saturation).
module tb_data_mem_dp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 13;
  localparam int unsigned CW = 3;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  data_mem_dp_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  data_mem_dp #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (6000),
    .CNT_W  (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_re, a_we;
    logic [12:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wd;
    logic        b_req, b_we;
    logic [12:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wd;
    logic        gnt, a_rv;
    logic [31:0] a_rd;
    logic        a_err, b_rv;
    logic [31:0] b_rd;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic a_re, a_we, input logic [12:0] a_addr, input logic [3:0] a_be,
    input logic [31:0] a_wd,
    input logic b_req, b_we, input logic [12:0] b_addr, input logic [3:0] b_be,
    input logic [31:0] b_wd,
    input logic gnt, a_rv, input logic [31:0] a_rd, input logic a_err, b_rv,
    input logic [31:0] b_rd, input logic [2:0] cnt);
    vec_t v;
    v.a_re = a_re;   v.a_we = a_we;   v.a_addr = a_addr; v.a_be = a_be; v.a_wd = a_wd;
    v.b_req = b_req; v.b_we = b_we;   v.b_addr = b_addr; v.b_be = b_be; v.b_wd = b_wd;
    v.gnt = gnt;     v.a_rv = a_rv;   v.a_rd = a_rd;     v.a_err = a_err;
    v.b_rv = b_rv;   v.b_rd = b_rd;   v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a_re = v.a_re;   bus.a_we = v.a_we;   bus.a_addr = v.a_addr;
    bus.a_be = v.a_be;   bus.a_wdata = v.a_wd;
    bus.b_req = v.b_req; bus.b_we = v.b_we;   bus.b_addr = v.b_addr;
    bus.b_be = v.b_be;   bus.b_wdata = v.b_wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t idle;

  initial begin
    n_chk = 0;
    n_bad = 0;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with B requesting: grant must stay low.
    rst_n = 1'b0;
    drive(idle);
    bus.b_req = 1'b1;
    step();
    step();
    chk("rst_b_gnt", 32'(bus.b_gnt), 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
    chk("rst_b_rvalid", 32'(bus.b_rvalid), 0);
    chk("rst_a_err", 32'(bus.a_err), 0);
    chk("rst_cnt", 32'(bus.conflict_cnt), 0);
    bus.b_req = 1'b0;
    rst_n = 1'b1;

    //              a: re we addr     be   wdata         b: rq we addr     be   wdata
    //              exp: gnt arv a_rdata      aerr brv b_rdata      cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 13'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 13'h10, 0, 0, 0, 0, 0, 0, 0,
                      0, 1, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 13'h20, 4'hF, 32'h11223344, 0, 0, 0, 0, 0,
                      0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 13'h20, 4'b0101, 32'hAABBCCDD, 0, 0, 0, 0, 0,
                      0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 13'h20, 0, 0,
                      1, 0, 32'hDEADBEEF, 0, 1, 32'h11BB33DD, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 32'hDEADBEEF, 0, 0, 32'h11BB33DD, 0));
    for (int i = 1; i <= 3; i++) begin
      vecs.push_back(mk(0, 1, 13'h30, 4'hF, 32'(i), 1, 0, 13'h30, 0, 0,
                        0, 0, 32'hDEADBEEF, 0, 0, 32'h11BB33DD, 3'(i)));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 13'h30, 0, 0,
                      1, 0, 32'hDEADBEEF, 0, 1, 32'h3, 3));
    vecs.push_back(mk(0, 1, 13'h40, 4'hF, 32'h5A5A5A5A, 0, 0, 0, 0, 0,
                      0, 0, 32'hDEADBEEF, 0, 0, 32'h3, 3));
    vecs.push_back(mk(1, 0, 13'h40, 0, 0, 1, 0, 13'h40, 0, 0,
                      1, 1, 32'h5A5A5A5A, 0, 1, 32'h5A5A5A5A, 3));
    vecs.push_back(mk(0, 1, 13'h60, 4'hF, 32'hCAFEF00D, 1, 1, 13'h61, 4'hF, 32'h12345678,
                      1, 0, 32'h5A5A5A5A, 0, 0, 32'h5A5A5A5A, 3));
    vecs.push_back(mk(1, 0, 13'h61, 0, 0, 1, 0, 13'h60, 0, 0,
                      1, 1, 32'h12345678, 0, 1, 32'hCAFEF00D, 3));
    vecs.push_back(mk(1, 0, 13'h60, 0, 0, 1, 1, 13'h60, 4'hF, 32'hFFFFFFFF,
                      0, 1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 4));
    vecs.push_back(mk(0, 1, 13'h50, 4'hF, 32'h0BADC0DE, 0, 0, 0, 0, 0,
                      0, 0, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 4));
    vecs.push_back(mk(1, 1, 13'h50, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 0,
                      0, 0, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D, 4));
    vecs.push_back(mk(1, 0, 13'h50, 0, 0, 0, 0, 0, 0, 0,
                      0, 1, 32'h0BADC0DE, 0, 0, 32'hCAFEF00D, 4));
    vecs.push_back(mk(1, 0, 13'h1800, 0, 0, 0, 0, 0, 0, 0,
                      0, 1, 0, 1, 0, 32'hCAFEF00D, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 13'h1800, 4'hF, 32'h77777777,
                      1, 0, 0, 0, 0, 32'hCAFEF00D, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 13'h1800, 0, 0,
                      1, 0, 0, 0, 1, 0, 4));
    vecs.push_back(mk(0, 1, 13'h1800, 4'hF, 32'h55555555, 0, 0, 0, 0, 0,
                      0, 0, 0, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 13'h176F, 4'hF, 32'h13579BDF, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 13'h176F, 0, 0,
                      1, 0, 0, 0, 1, 32'h13579BDF, 4));
    vecs.push_back(mk(0, 1, 13'h10, 4'h0, 32'h0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 32'h13579BDF, 4));
    vecs.push_back(mk(1, 0, 13'h10, 0, 0, 0, 0, 0, 0, 0,
                      0, 1, 32'hDEADBEEF, 0, 0, 32'h13579BDF, 4));
    for (int i = 5; i <= 8; i++) begin
      vecs.push_back(mk(0, 1, 13'h70, 4'hF, 32'h0, 1, 0, 13'h70, 0, 0,
                        0, 0, 32'hDEADBEEF, 0, 0, 32'h13579BDF, (i > 7) ? 3'd7 : 3'(i)));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 13'h60, 0, 0,
                      1, 0, 32'hDEADBEEF, 0, 1, 32'hCAFEF00D, 7));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_b_gnt", i), 32'(bus.b_gnt), 32'(vecs[i].gnt));
      step();
      chk($sformatf("v%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(vecs[i].a_rv));
      chk($sformatf("v%0d_a_rdata", i), bus.a_rdata, vecs[i].a_rd);
      chk($sformatf("v%0d_a_err", i), 32'(bus.a_err), 32'(vecs[i].a_err));
      chk($sformatf("v%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(vecs[i].b_rv));
      chk($sformatf("v%0d_b_rdata", i), bus.b_rdata, vecs[i].b_rd);
      chk($sformatf("v%0d_cnt", i), 32'(bus.conflict_cnt), 32'(vecs[i].cnt));
    end

    // Mid-stream reset: five denied cycles, then a granted B write aborted by reset.
    rst_n = 1'b0;
    drive(idle);
    step();
    rst_n = 1'b1;
    drive(mk(0, 1, 13'h80, 4'hF, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 0, 13'h80, 0, 0, 1, 1, 13'h80, 4'hF, 32'h99999999,
             0, 0, 0, 0, 0, 0, 0));
    repeat (5) step();
    chk("mr_cnt5", 32'(bus.conflict_cnt), 5);
    chk("mr_a_rdata", bus.a_rdata, 32'h11111111);
    drive(mk(0, 0, 0, 0, 0, 1, 1, 13'h80, 4'hF, 32'h99999999, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mr_gnt_pre", 32'(bus.b_gnt), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_gnt_rst", 32'(bus.b_gnt), 0);
    chk("mr_cnt_rst", 32'(bus.conflict_cnt), 0);
    chk("mr_a_rdata_rst", bus.a_rdata, 0);
    chk("mr_a_rvalid_rst", 32'(bus.a_rvalid), 0);
    step();
    drive(idle);
    #1;
    rst_n = 1'b1;
    drive(mk(1, 0, 13'h80, 0, 0, 1, 0, 13'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mr_post_gnt", 32'(bus.b_gnt), 1);
    step();
    chk("mr_post_a_rdata", bus.a_rdata, 32'h11111111);
    chk("mr_post_b_rdata", bus.b_rdata, 32'h11111111);
    chk("mr_post_a_rvalid", 32'(bus.a_rvalid), 1);
    chk("mr_post_b_rvalid", 32'(bus.b_rvalid), 1);
    chk("mr_post_cnt", 32'(bus.conflict_cnt), 0);
    drive(idle);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
